// File: rtl/jk_button_driver.sv
// Debounces two raw pushbuttons and classifies presses into single-cycle set/reset/toggle j/k pulses.
// Optional auto-repeat while held is built when JKDRV_REPEAT_EN is defined.
module jk_button_driver #(
    parameter int DEB_CNT = 8,
    parameter int WIN     = 4,
    parameter int REP_CNT = 64
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_set,
    input  logic btn_rst,
    output logic j,
    output logic k,
    output logic busy
);

    localparam int DW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
    localparam int TW = (WIN > 2) ? $clog2(WIN) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PAIR = 2'd1, EMIT = 2'd2, HOLD = 2'd3} state_t;

    // Channel 1 is set, channel 0 is reset throughout.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    deb_r;
    logic [1:0]    deb_d_r;
    logic [DW-1:0] cnt_r [2];
    logic [1:0]    rise_s;
    logic          other_rise_s;

    state_t        state_r, state_nx;
    logic [1:0]    code_r, code_nx;
    logic [TW-1:0] timer_r, timer_nx;
    logic          j_r, k_r, busy_r;

`ifdef JKDRV_REPEAT_EN
    localparam int RW = (REP_CNT > 2) ? $clog2(REP_CNT) : 1;
    logic [RW-1:0] rep_r, rep_nx;
`endif

    assign raw_s        = {btn_set, btn_rst};
    assign rise_s       = deb_r & ~deb_d_r;
    assign other_rise_s = code_r[1] ? rise_s[0] : rise_s[1];

    // Synchronisers and per-channel debounce counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            deb_r    <= 2'b00;
            deb_d_r  <= 2'b00;
            cnt_r[0] <= '0;
            cnt_r[1] <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DW'(DEB_CNT - 1)) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + DW'(1);
                end
            end
        end
    end

    // Command classification next-state logic.
    always_comb begin
        state_nx = state_r;
        code_nx  = code_r;
        timer_nx = timer_r;
`ifdef JKDRV_REPEAT_EN
        rep_nx   = rep_r;
`endif
        case (state_r)
            IDLE: begin
                if (rise_s == 2'b11) begin
                    code_nx  = 2'b11;
                    state_nx = EMIT;
                end else if (rise_s[1]) begin
                    code_nx  = 2'b10;
                    timer_nx = '0;
                    state_nx = PAIR;
                end else if (rise_s[0]) begin
                    code_nx  = 2'b01;
                    timer_nx = '0;
                    state_nx = PAIR;
                end else begin
                    state_nx = IDLE;
                end
            end
            PAIR: begin
                if (other_rise_s) begin
                    code_nx  = 2'b11;
                    state_nx = EMIT;
                end else if (timer_r == TW'(WIN - 1)) begin
                    state_nx = EMIT;
                end else begin
                    timer_nx = timer_r + TW'(1);
                end
            end
            EMIT: begin
                state_nx = HOLD;
`ifdef JKDRV_REPEAT_EN
                rep_nx   = '0;
`endif
            end
            HOLD: begin
                if (deb_r == 2'b00) begin
                    state_nx = IDLE;
`ifdef JKDRV_REPEAT_EN
                end else if (rep_r == RW'(REP_CNT - 1)) begin
                    rep_nx   = '0;
                    state_nx = EMIT;
                end else begin
                    rep_nx   = rep_r + RW'(1);
`else
                end else begin
                    state_nx = HOLD;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                code_nx  = 2'b00;
            end
        endcase
    end

    // FSM state and registered outputs, asserted on the edge that enters EMIT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= IDLE;
            code_r  <= 2'b00;
            timer_r <= '0;
            j_r     <= 1'b0;
            k_r     <= 1'b0;
            busy_r  <= 1'b0;
`ifdef JKDRV_REPEAT_EN
            rep_r   <= '0;
`endif
        end else begin
            state_r <= state_nx;
            code_r  <= code_nx;
            timer_r <= timer_nx;
            j_r     <= (state_nx == EMIT) & code_nx[1];
            k_r     <= (state_nx == EMIT) & code_nx[0];
            busy_r  <= (state_nx != IDLE);
`ifdef JKDRV_REPEAT_EN
            rep_r   <= rep_nx;
`endif
        end
    end

    assign j    = j_r;
    assign k    = k_r;
    assign busy = busy_r;

endmodule
